// File: rtl/pd_block_assembler_if.sv
// Receive-path and hash-core signals of the block assembler, grouped as one bundle.
// The slave side is the assembler. The master side is the upstream stage together with the hash core.
interface pd_block_assembler_if;
  // valid/ready: a word moves on a rising edge only when in_valid && in_ready;
  // in_ready depends on FSM state alone, never on in_valid, and in_word is
  // don't-care while in_ready is low.
  logic         abort;
  logic         in_valid;
  logic [31:0]  in_word;
  logic         in_ready;
  logic         hash_done;
  logic [1:0]   hash_select;
  logic [511:0] chunk_1;
  logic [127:0] chunk_2;
  logic         start_hash;
  logic         block_done;
  logic         timeout_err;

  modport slave (
    input  abort, in_valid, in_word, hash_done,
    output in_ready, hash_select, chunk_1, chunk_2, start_hash, block_done, timeout_err
  );

  modport master (
    output abort, in_valid, in_word, hash_done,
    input  in_ready, hash_select, chunk_1, chunk_2, start_hash, block_done, timeout_err
  );
endinterface

// File: rtl/pd_block_assembler.sv
// Collects a 20-word block header into chunk_1/chunk_2 and sequences the two-pass hash.
// The current FSM state is visible on dbg_state.
module pd_block_assembler #(
  parameter int HASH_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  pd_block_assembler_if.slave    bus,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_HASH1 = 3'd1,
    S_WAIT1 = 3'd2,
    S_HASH2 = 3'd3,
    S_WAIT2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int TW = $clog2(HASH_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(HASH_TIMEOUT - 1);

  state_t         state, state_nxt;
  logic [4:0]     word_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           accept;
  logic           tmo_hit;
  logic           ready_c;
  logic           start_c;
  logic           done_c;
  logic           sel_c;
  logic           err_q;
  logic [511:0]   chunk_1_q;
  logic [127:0]   chunk_2_q;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    tmo_hit   = 1'b0;
    ready_c   = 1'b0;
    start_c   = 1'b0;
    done_c    = 1'b0;
    sel_c     = 1'b0;
    case (state)
      S_LOAD: begin
        ready_c = 1'b1;
        accept  = bus.in_valid;
        if (bus.in_valid && word_cnt == 5'd19) state_nxt = S_HASH1;
      end
      S_HASH1: begin
        start_c   = 1'b1;
        state_nxt = S_WAIT1;
      end
      S_WAIT1: begin
        // hash_done beats a timeout that expires in the same cycle
        if (bus.hash_done) state_nxt = S_HASH2;
        else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_HASH2: begin
        sel_c     = 1'b1;
        start_c   = 1'b1;
        state_nxt = S_WAIT2;
      end
      S_WAIT2: begin
        sel_c = 1'b1;
        if (bus.hash_done) state_nxt = S_DONE;
        else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        done_c    = 1'b1;
        state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
    // abort discards the block but keeps the chunks and the error flag
    if (bus.abort) begin
      state_nxt = S_LOAD;
      accept    = 1'b0;
      tmo_hit   = 1'b0;
      start_c   = 1'b0;
      done_c    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      word_cnt  <= 5'd0;
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
      chunk_1_q <= '0;
      chunk_2_q <= '0;
    end else begin
      state <= state_nxt;

      if (bus.abort || tmo_hit) word_cnt <= 5'd0;
      else if (accept) word_cnt <= (word_cnt == 5'd19) ? 5'd0 : word_cnt + 5'd1;

      if (state == S_WAIT1 || state == S_WAIT2) tmo_cnt <= tmo_cnt + 1'b1;
      else tmo_cnt <= '0;

      if (tmo_hit) err_q <= 1'b1;
      else if (accept) err_q <= 1'b0;

      // Big-endian placement: word 0 lands in the top 32 bits of chunk_1
      if (accept) begin
        for (int i = 0; i < 16; i++)
          if (word_cnt == 5'(i)) chunk_1_q[32*(15-i) +: 32] <= bus.in_word;
        for (int i = 0; i < 4; i++)
          if (word_cnt == 5'(16 + i)) chunk_2_q[32*(3-i) +: 32] <= bus.in_word;
      end
    end
  end

  assign bus.in_ready    = ready_c;
  assign bus.start_hash  = start_c;
  assign bus.block_done  = done_c;
  assign bus.hash_select = {1'b0, sel_c};
  assign bus.timeout_err = err_q;
  assign bus.chunk_1     = chunk_1_q;
  assign bus.chunk_2     = chunk_2_q;
  assign dbg_state       = state;

endmodule

// File: doc/pd_block_assembler.md
Name: pd_block_assembler

Overview:
- Packet-decoder stage directly upstream of the chunk decoder.
- Collects a 640-bit (20 x 32-bit word) block header from the receive path through a valid/ready handshake.
- Presents the header as chunk_1 (words 0-15) and chunk_2 (words 16-19).
- Sequences the two-pass hash: drives hash_select, issues start pulses to the hash core and waits for each pass to complete.

Parameters:
- HASH_TIMEOUT, 1024, maximum cycles to wait for hash_done in either pass before declaring an error.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- abort  input  1  synchronous discard of the current block; returns to LOAD
- in_valid  input  1  in_word is valid this cycle
- in_word  input  32  next header word, first-received word first
- in_ready  output  1  block accepts a word this cycle
- hash_done  input  1  one-cycle pulse from the hash core: current pass finished
- hash_select  output  2  0 = pass 1 (chunk_1), 1 = pass 2 (padded chunk_2)
- chunk_1  output  512  words 0-15
- chunk_2  output  128  words 16-19
- start_hash  output  1  one-cycle pulse: begin pass selected by hash_select
- block_done  output  1  one-cycle pulse: both passes complete
- timeout_err  output  1  sticky; set on a hash timeout, cleared by rst or by the next accepted word

Behaviour:
- Reset values (rst high at a rising edge):
  - state = LOAD, word count = 0, in_ready = 1, hash_select = 0.
  - start_hash = 0, block_done = 0, timeout_err = 0.
  - chunk_1 = 0, chunk_2 = 0, timeout counter = 0.
  - rst overrides abort and all other inputs.
- Handshake: a word is accepted when in_valid && in_ready at a rising edge.
  - in_ready = 1 only in LOAD.
  - in_word is ignored when in_ready = 0.
  - No combinational path from in_valid to in_ready.
- Word placement: word k (k = 0..19, acceptance order), big-endian.
  - k < 16: chunk_1[511-32k -: 32].
  - k >= 16: chunk_2[127-32(k-16) -: 32].
  - Chunk registers change only on an accepted word; they hold stable from HASH1 through DONE.
- States and transitions:
  - LOAD: accept words, count++.
    - On acceptance of word 19: count -> 0, next state HASH1.
    - Latency: HASH1 is the cycle immediately after the 20th accepting edge.
  - HASH1: hash_select = 0, start_hash = 1 for exactly this cycle. Next state WAIT1; timeout counter cleared.
  - WAIT1: hash_select = 0; timeout counter++ each cycle.
    - hash_done -> HASH2.
    - Counter reaching HASH_TIMEOUT -> timeout_err = 1, state LOAD, count 0.
  - HASH2: hash_select = 1, start_hash = 1 for this cycle. Next state WAIT2; counter cleared.
  - WAIT2: same rules as WAIT1 with hash_select = 1; hash_done -> DONE.
  - DONE: block_done = 1 for this cycle; hash_select returns to 0. Next state LOAD.
- Boundary rules:
  - hash_done outside WAIT1/WAIT2, including the start_hash cycle, is ignored.
  - hash_done and timeout in the same cycle: hash_done wins.
  - abort in any state: next state LOAD, count 0, start_hash/block_done forced 0 that cycle, chunk registers retained, timeout_err unchanged.
  - abort coincident with an accepted word: the word is discarded.
  - in_valid held high continuously: one word per cycle, 20 cycles to fill.
  - Bubbles (in_valid low) do not disturb the count.
  - After DONE, the next block starts at word 0 and overwrites the chunks progressively.
  - hash_select upper bit is always 0.

Test Plan:
- Back-to-back load of words 0x00000000..0x00000013:
  - chunk_1[511:480] = 0, chunk_1[31:0] = 0x0000000F, chunk_2 = 0x00000010_00000011_00000012_00000013.
  - start_hash high exactly one cycle after the 20th accept, with hash_select = 0.
- Full flow: hash_done 5 cycles after each start_hash -> sequence HASH1, WAIT1, HASH2 (hash_select = 1), WAIT2, then a single block_done pulse; in_ready = 0 from HASH1 to DONE inclusive, 1 again the next cycle.
- Timeout with HASH_TIMEOUT = 8 and no hash_done -> timeout_err = 1 after 8 WAIT1 cycles, state LOAD, in_ready = 1; timeout_err clears on the next accepted word.
- abort after 7 accepted words -> count resets; the next 20 words fill from chunk_1[511:480]; no start_hash before the 20th word.
- Spurious hash_done during the LOAD and HASH1 cycles -> ignored; FSM still waits for a hash_done in WAIT1.
- rst asserted in WAIT2 -> next cycle all outputs at reset values, no block_done; a subsequent full block completes normally.
